// File: rtl/iq_wakeup_sched_if.sv
// iq_wakeup_sched_if
//   Enqueue and issue buses of the issue queue.
//   master : instruction router + functional unit side
//            (drives the enqueue request/payload and iss_ready)
//   slave  : the issue queue
//            (drives queue_ready, the issued payload and the PRF read request)
interface iq_wakeup_sched_if #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3
);
    // enqueue side
    logic                                   inst_valid;
    logic                                   queue_ready;
    logic [INST_ID_BITS-1:0]                inst_id;
    logic [31:0]                            raw_instr;
    logic [63:0]                            instr_pc;
    logic [MAX_OPERANDS-1:0]                prn_input_valid;
    logic [MAX_OPERANDS-1:0]                prn_input_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_input;
    logic [MAX_OPERANDS-1:0]                prn_output_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prn_output;
    // issue side
    logic                                   iss_valid;
    logic                                   iss_ready;
    logic [INST_ID_BITS-1:0]                iss_inst_id;
    logic [31:0]                            iss_raw_instr;
    logic [63:0]                            iss_instr_pc;
    logic [MAX_OPERANDS-1:0]                iss_prn_output_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  iss_prn_output;
    logic [MAX_OPERANDS-1:0]                prf_read_enable;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  prf_read_prn;

    modport master (
        output inst_valid, inst_id, raw_instr, instr_pc,
               prn_input_valid, prn_input_ready, prn_input,
               prn_output_valid, prn_output, iss_ready,
        input  queue_ready, iss_valid, iss_inst_id, iss_raw_instr, iss_instr_pc,
               iss_prn_output_valid, iss_prn_output, prf_read_enable, prf_read_prn
    );

    modport slave (
        input  inst_valid, inst_id, raw_instr, instr_pc,
               prn_input_valid, prn_input_ready, prn_input,
               prn_output_valid, prn_output, iss_ready,
        output queue_ready, iss_valid, iss_inst_id, iss_raw_instr, iss_instr_pc,
               iss_prn_output_valid, iss_prn_output, prf_read_enable, prf_read_prn
    );
endinterface

// File: rtl/iq_wakeup_sched.sv
// iq_wakeup_sched
//   Age-ordered issue queue with multi-port tag wakeup and a registered
//   valid/ready issue port. Oldest ready entry is selected each cycle.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     flush          synchronous clear of all entries and the output register
//     set_prn_ready  [WAKE_PORTS][MAX_OPERANDS] wakeup strobes
//     set_prn        [WAKE_PORTS][MAX_OPERANDS] wakeup tags
//     occupancy      valid entries (output register excluded)
//     bus            enqueue/issue interface (slave modport)
//   Build option: IQ_SELF_WAKE_EN -- destination tags of the entry being
//   loaded into the output register also act as a wakeup at that edge.
module iq_wakeup_sched #(
    parameter int DEPTH        = 8,
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int WAKE_PORTS   = 4,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                flush,
    input  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0]             set_prn_ready,
    input  logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
    output logic [CNT_W-1:0]                                    occupancy,
    iq_wakeup_sched_if.slave                                    bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] tags_t;

    // entry storage
    logic [DEPTH-1:0]                    ent_valid;
    logic [DEPTH-1:0][DEPTH-1:0]         age;        // age[i][j]: entry j older than i
    logic [DEPTH-1:0][MAX_OPERANDS-1:0]  src_rdy;    // unused slots held ready
    logic [DEPTH-1:0][MAX_OPERANDS-1:0]  src_used;
    logic [DEPTH-1:0]                    [MAX_OPERANDS-1:0][PRN_BITS-1:0] src_tag;
    logic [DEPTH-1:0][MAX_OPERANDS-1:0]  dst_valid;
    logic [DEPTH-1:0]                    [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst_tag;
    logic [DEPTH-1:0][INST_ID_BITS-1:0]  ent_id;
    logic [DEPTH-1:0][31:0]              ent_raw;
    logic [DEPTH-1:0][63:0]              ent_pc;

    // output register
    logic                                iss_valid_q;
    logic [INST_ID_BITS-1:0]             iss_id_q;
    logic [31:0]                         iss_raw_q;
    logic [63:0]                         iss_pc_q;
    logic [MAX_OPERANDS-1:0]             iss_dv_q;
    tags_t                               iss_dt_q;
    logic [MAX_OPERANDS-1:0]             iss_su_q;
    tags_t                               iss_st_q;
    logic [CNT_W-1:0]                    occ_q;

    logic [DEPTH-1:0]                    ent_rdy;
    logic                                sel_any;
    logic [IDX_W-1:0]                    sel_idx;
    logic [IDX_W-1:0]                    free_idx;
    logic                                free_found;
    logic [DEPTH-1:0]                    free_mask;
    logic                                load;
    logic                                enq;
    logic [MAX_OPERANDS-1:0]             sw_valid;
    tags_t                               sw_tag;
    logic [DEPTH-1:0][MAX_OPERANDS-1:0]  wake_src;
    logic [MAX_OPERANDS-1:0]             wake_in;

    function automatic logic tag_hit(
        input logic [PRN_BITS-1:0]                                 tag,
        input logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0]             sv,
        input logic [WAKE_PORTS-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] st,
        input logic [MAX_OPERANDS-1:0]                             swv,
        input tags_t                                               swt
    );
        logic hit;
        hit = 1'b0;
        for (int unsigned w = 0; w < WAKE_PORTS; w++)
            for (int unsigned k = 0; k < MAX_OPERANDS; k++)
                if (sv[w][k] && st[w][k] == tag) hit = 1'b1;
        for (int unsigned k = 0; k < MAX_OPERANDS; k++)
            if (swv[k] && swt[k] == tag) hit = 1'b1;
        return hit;
    endfunction

    // Ready vector and oldest-ready select; the age matrix makes the
    // winner unique, so the last-match loop is a plain encoder.
    always_comb begin
        ent_rdy = '0;
        sel_any = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            ent_rdy[i] = ent_valid[i] & (&src_rdy[i]);
        for (int unsigned i = 0; i < DEPTH; i++)
            if (ent_rdy[i] && ((age[i] & ent_rdy) == '0)) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(i);
            end
    end

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++)
            if (!ent_valid[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
    end

    assign load = sel_any && (!iss_valid_q || bus.iss_ready);
    assign enq  = bus.inst_valid && bus.queue_ready;

    always_comb begin
        free_mask = '0;
        if (load) free_mask[sel_idx] = 1'b1;
    end

`ifdef IQ_SELF_WAKE_EN
    assign sw_valid = load ? dst_valid[sel_idx] : '0;
`else
    assign sw_valid = '0;
`endif
    assign sw_tag = dst_tag[sel_idx];

    always_comb begin
        wake_src = '0;
        wake_in  = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            for (int unsigned k = 0; k < MAX_OPERANDS; k++)
                wake_src[i][k] = tag_hit(src_tag[i][k], set_prn_ready, set_prn, sw_valid, sw_tag);
        for (int unsigned k = 0; k < MAX_OPERANDS; k++)
            wake_in[k] = tag_hit(bus.prn_input[k], set_prn_ready, set_prn, sw_valid, sw_tag);
    end

    // Entry array. Allocation uses the registered free vector, so it never
    // collides with the entry being freed at the same edge; the new row
    // excludes that freed entry so it is not counted as older.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_valid <= '0;
            age       <= '0;
            src_rdy   <= '0;
            src_used  <= '0;
            src_tag   <= '0;
            dst_valid <= '0;
            dst_tag   <= '0;
            ent_id    <= '0;
            ent_raw   <= '0;
            ent_pc    <= '0;
        end else if (flush) begin
            ent_valid <= '0;
            age       <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++)
                for (int unsigned k = 0; k < MAX_OPERANDS; k++)
                    if (ent_valid[i] && wake_src[i][k]) src_rdy[i][k] <= 1'b1;
            if (load) begin
                ent_valid[sel_idx] <= 1'b0;
                for (int unsigned i = 0; i < DEPTH; i++) age[i][sel_idx] <= 1'b0;
            end
            if (enq) begin
                ent_valid[free_idx] <= 1'b1;
                age[free_idx]       <= ent_valid & ~free_mask;
                src_rdy[free_idx]   <= ~bus.prn_input_valid | bus.prn_input_ready | wake_in;
                src_used[free_idx]  <= bus.prn_input_valid;
                src_tag[free_idx]   <= bus.prn_input;
                dst_valid[free_idx] <= bus.prn_output_valid;
                dst_tag[free_idx]   <= bus.prn_output;
                ent_id[free_idx]    <= bus.inst_id;
                ent_raw[free_idx]   <= bus.raw_instr;
                ent_pc[free_idx]    <= bus.instr_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + CNT_W'(enq) - CNT_W'(load);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || (!rst && flush)) begin
            iss_valid_q <= 1'b0;
            iss_id_q    <= '0;
            iss_raw_q   <= '0;
            iss_pc_q    <= '0;
            iss_dv_q    <= '0;
            iss_dt_q    <= '0;
            iss_su_q    <= '0;
            iss_st_q    <= '0;
        end else if (load) begin
            iss_valid_q <= 1'b1;
            iss_id_q    <= ent_id[sel_idx];
            iss_raw_q   <= ent_raw[sel_idx];
            iss_pc_q    <= ent_pc[sel_idx];
            iss_dv_q    <= dst_valid[sel_idx];
            iss_dt_q    <= dst_tag[sel_idx];
            iss_su_q    <= src_used[sel_idx];
            iss_st_q    <= src_tag[sel_idx];
        end else if (iss_valid_q && bus.iss_ready) begin
            iss_valid_q <= 1'b0;
            iss_id_q    <= '0;
            iss_raw_q   <= '0;
            iss_pc_q    <= '0;
            iss_dv_q    <= '0;
            iss_dt_q    <= '0;
            iss_su_q    <= '0;
            iss_st_q    <= '0;
        end
    end

    assign occupancy                = occ_q;
    assign bus.queue_ready          = (occ_q < CNT_W'(DEPTH));
    assign bus.iss_valid            = iss_valid_q;
    assign bus.iss_inst_id          = iss_id_q;
    assign bus.iss_raw_instr        = iss_raw_q;
    assign bus.iss_instr_pc         = iss_pc_q;
    assign bus.iss_prn_output_valid = iss_dv_q;
    assign bus.iss_prn_output       = iss_dt_q;
    assign bus.prf_read_enable      = {MAX_OPERANDS{iss_valid_q}} & iss_su_q;
    assign bus.prf_read_prn         = iss_st_q;
endmodule

// File: tb/tb_iq_wakeup_sched.sv
// tb_iq_wakeup_sched
//   Directed bench for iq_wakeup_sched (DEPTH=8, 3 operands, 4 wake ports).
module tb_iq_wakeup_sched;
    localparam int DEPTH = 8;
    localparam int IB    = 6;
    localparam int PB    = 6;
    localparam int MO    = 3;
    localparam int WP    = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           flush;
    logic [WP-1:0][MO-1:0]          set_prn_ready;
    logic [WP-1:0][MO-1:0][PB-1:0]  set_prn;
    logic [CW-1:0]                  occupancy;
    int                             errors = 0;
    int                             checks = 0;
    int                             order [8] = '{24, 16, 17, 18, 19, 20, 21, 22};
    int                             wtag  [8] = '{50, 40, 41, 42, 43, 44, 45, 46};

    iq_wakeup_sched_if #(.INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO)) bus ();

    iq_wakeup_sched #(
        .DEPTH(DEPTH), .INST_ID_BITS(IB), .PRN_BITS(PB),
        .MAX_OPERANDS(MO), .WAKE_PORTS(WP)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .set_prn_ready(set_prn_ready), .set_prn(set_prn),
        .occupancy(occupancy), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] raw_of(input logic [5:0] id);
        return {16'hA5A5, 10'd0, id};
    endfunction

    function automatic logic [63:0] pc_of(input logic [5:0] id);
        return {56'h80000000, 2'b00, id};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_enq(input logic [5:0] id, input logic [2:0] used, input logic [2:0] rdy,
                             input logic [2:0][5:0] tags, input logic [2:0] dv,
                             input logic [2:0][5:0] dtags);
        bus.inst_valid       = 1'b1;
        bus.inst_id          = id;
        bus.raw_instr        = raw_of(id);
        bus.instr_pc         = pc_of(id);
        bus.prn_input_valid  = used;
        bus.prn_input_ready  = rdy;
        bus.prn_input        = tags;
        bus.prn_output_valid = dv;
        bus.prn_output       = dtags;
    endtask

    task automatic no_enq();
        bus.inst_valid = 1'b0;
    endtask

    task automatic clear_wake();
        set_prn_ready = '0;
        set_prn       = '0;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        clear_wake();
        drive_enq(6'd0, 3'b000, 3'b000, '0, 3'b000, '0);
        no_enq();
        bus.iss_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_queue_ready", 64'(bus.queue_ready), 64'd1);
        chk("rst_iss_valid",   64'(bus.iss_valid), 64'd0);
        chk("rst_occupancy",   64'(occupancy), 64'd0);
        chk("rst_iss_id",      64'(bus.iss_inst_id), 64'd0);
        chk("rst_prf_en",      64'(bus.prf_read_enable), 64'd0);
        chk("rst_prf_prn",     64'(bus.prf_read_prn), 64'd0);

        // single ready instruction, one-cycle latency after acceptance
        drive_enq(6'd5, 3'b011, 3'b011, {6'd0, 6'd4, 6'd3}, 3'b001, {6'd0, 6'd0, 6'd20});
        tick();
        no_enq();
        chk("t1_occ_accept", 64'(occupancy), 64'd1);
        chk("t1_valid_early", 64'(bus.iss_valid), 64'd0);
        tick();
        chk("t1_valid",   64'(bus.iss_valid), 64'd1);
        chk("t1_id",      64'(bus.iss_inst_id), 64'd5);
        chk("t1_raw",     64'(bus.iss_raw_instr), 64'(raw_of(6'd5)));
        chk("t1_pc",      bus.iss_instr_pc, pc_of(6'd5));
        chk("t1_prf_en",  64'(bus.prf_read_enable), 64'd3);
        chk("t1_prf_prn", 64'(bus.prf_read_prn), 64'({6'd0, 6'd4, 6'd3}));
        chk("t1_dst_v",   64'(bus.iss_prn_output_valid), 64'd1);
        chk("t1_dst",     64'(bus.iss_prn_output), 64'({6'd0, 6'd0, 6'd20}));
        chk("t1_occ",     64'(occupancy), 64'd0);
        tick();
        chk("t1_drain", 64'(bus.iss_valid), 64'd0);

        // older unready entry bypassed, then issued after wakeup on lane [3][0]
        drive_enq(6'd1, 3'b001, 3'b000, {6'd0, 6'd0, 6'd9}, 3'b000, '0);
        tick();
        drive_enq(6'd2, 3'b001, 3'b001, {6'd0, 6'd0, 6'd10}, 3'b000, '0);
        tick();
        no_enq();
        set_prn_ready[3][0] = 1'b1;
        set_prn[3][0]       = 6'd9;
        chk("t2_occ2",  64'(occupancy), 64'd2);
        chk("t2_idle",  64'(bus.iss_valid), 64'd0);
        tick();
        clear_wake();
        chk("t2_first", 64'(bus.iss_inst_id), 64'd2);
        chk("t2_occ1",  64'(occupancy), 64'd1);
        tick();
        chk("t2_second_v", 64'(bus.iss_valid), 64'd1);
        chk("t2_second",   64'(bus.iss_inst_id), 64'd1);
        chk("t2_occ0",     64'(occupancy), 64'd0);
        tick();
        chk("t2_drain", 64'(bus.iss_valid), 64'd0);

        // entry 0 freed early so age order differs from index order
        drive_enq(6'd25, 3'b001, 3'b001, {6'd0, 6'd0, 6'd1}, 3'b000, '0);
        tick();
        drive_enq(6'd24, 3'b001, 3'b000, {6'd0, 6'd0, 6'd50}, 3'b000, '0);
        tick();
        chk("t3_id25",  64'(bus.iss_inst_id), 64'd25);
        chk("t3_occ1",  64'(occupancy), 64'd1);
        drive_enq(6'd16, 3'b001, 3'b000, {6'd0, 6'd0, 6'd40}, 3'b000, '0);
        tick();
        chk("t3_clear", 64'(bus.iss_valid), 64'd0);
        for (int n = 0; n < 6; n++) begin
            drive_enq(6'(17 + n), 3'b001, 3'b000, {6'd0, 6'd0, 6'(41 + n)}, 3'b000, '0);
            tick();
        end
        no_enq();
        chk("t3_full_occ", 64'(occupancy), 64'd8);
        chk("t3_full_qr",  64'(bus.queue_ready), 64'd0);
        drive_enq(6'd63, 3'b001, 3'b001, {6'd0, 6'd0, 6'd2}, 3'b000, '0);
        tick();
        no_enq();
        tick();
        chk("t3_drop_occ", 64'(occupancy), 64'd8);
        chk("t3_drop_iss", 64'(bus.iss_valid), 64'd0);

        // wake all eight in one cycle; issue follows age
        for (int n = 0; n < 8; n++) begin
            set_prn_ready[n / 3][n % 3] = 1'b1;
            set_prn[n / 3][n % 3]       = PB'(wtag[n]);
        end
        tick();
        clear_wake();
        chk("t4_wake_occ", 64'(occupancy), 64'd8);
        chk("t4_wake_iss", 64'(bus.iss_valid), 64'd0);
        for (int n = 0; n < 8; n++) begin
            tick();
            chk("t4_order", 64'(bus.iss_inst_id), 64'(order[n]));
            chk("t4_occ",   64'(occupancy), 64'(7 - n));
        end
        chk("t4_qr", 64'(bus.queue_ready), 64'd1);
        tick();
        chk("t4_drain", 64'(bus.iss_valid), 64'd0);

        // stall with simultaneous enqueue+issue before it
        drive_enq(6'd7, 3'b001, 3'b001, {6'd0, 6'd0, 6'd11}, 3'b010, {6'd0, 6'd33, 6'd0});
        tick();
        chk("t5_occ_a", 64'(occupancy), 64'd1);
        drive_enq(6'd8, 3'b001, 3'b001, {6'd0, 6'd0, 6'd12}, 3'b000, '0);
        tick();
        no_enq();
        bus.iss_ready = 1'b0;
        chk("t5_id7",   64'(bus.iss_inst_id), 64'd7);
        chk("t5_occ_b", 64'(occupancy), 64'd1);
        for (int r = 0; r < 4; r++) begin
            tick();
            chk("t5_hold_v",   64'(bus.iss_valid), 64'd1);
            chk("t5_hold_id",  64'(bus.iss_inst_id), 64'd7);
            chk("t5_hold_pc",  bus.iss_instr_pc, pc_of(6'd7));
            chk("t5_hold_dv",  64'(bus.iss_prn_output_valid), 64'd2);
            chk("t5_hold_dt",  64'(bus.iss_prn_output), 64'({6'd0, 6'd33, 6'd0}));
            chk("t5_hold_prn", 64'(bus.prf_read_prn), 64'd11);
            chk("t5_hold_occ", 64'(occupancy), 64'd1);
        end
        bus.iss_ready = 1'b1;
        tick();
        chk("t5_next", 64'(bus.iss_inst_id), 64'd8);
        chk("t5_occ0", 64'(occupancy), 64'd0);
        tick();
        chk("t5_drain", 64'(bus.iss_valid), 64'd0);

        // flush beats enqueue, output register and queued entries
        bus.iss_ready = 1'b0;
        drive_enq(6'd40, 3'b001, 3'b001, {6'd0, 6'd0, 6'd1}, 3'b000, '0);
        tick();
        drive_enq(6'd41, 3'b001, 3'b000, {6'd0, 6'd0, 6'd55}, 3'b000, '0);
        tick();
        drive_enq(6'd42, 3'b001, 3'b000, {6'd0, 6'd0, 6'd56}, 3'b000, '0);
        tick();
        drive_enq(6'd43, 3'b001, 3'b000, {6'd0, 6'd0, 6'd57}, 3'b000, '0);
        tick();
        chk("t6_pre_occ", 64'(occupancy), 64'd3);
        chk("t6_pre_id",  64'(bus.iss_inst_id), 64'd40);
        flush = 1'b1;
        drive_enq(6'd44, 3'b001, 3'b001, {6'd0, 6'd0, 6'd1}, 3'b000, '0);
        tick();
        flush = 1'b0;
        no_enq();
        chk("t6_valid", 64'(bus.iss_valid), 64'd0);
        chk("t6_occ",   64'(occupancy), 64'd0);
        chk("t6_id",    64'(bus.iss_inst_id), 64'd0);
        chk("t6_qr",    64'(bus.queue_ready), 64'd1);
        chk("t6_prf",   64'(bus.prf_read_enable), 64'd0);
        bus.iss_ready = 1'b1;
        set_prn_ready[0] = 3'b111;
        set_prn[0]       = {6'd57, 6'd56, 6'd55};
        tick();
        clear_wake();
        tick();
        chk("t6_gone_v",   64'(bus.iss_valid), 64'd0);
        chk("t6_gone_occ", 64'(occupancy), 64'd0);

        // producer/dependent on tag 12
        drive_enq(6'd51, 3'b001, 3'b000, {6'd0, 6'd0, 6'd12}, 3'b000, '0);
        tick();
        drive_enq(6'd50, 3'b001, 3'b001, {6'd0, 6'd0, 6'd3}, 3'b001, {6'd0, 6'd0, 6'd12});
        tick();
        no_enq();
        chk("t7_occ2", 64'(occupancy), 64'd2);
        tick();
        chk("t7_prod", 64'(bus.iss_inst_id), 64'd50);
        chk("t7_occ1", 64'(occupancy), 64'd1);
        tick();
`ifdef IQ_SELF_WAKE_EN
        chk("t7_dep_self",  64'(bus.iss_inst_id), 64'd51);
        chk("t7_occ_self",  64'(occupancy), 64'd0);
`else
        chk("t7_wait_v",    64'(bus.iss_valid), 64'd0);
        chk("t7_wait_occ",  64'(occupancy), 64'd1);
        set_prn_ready[1][2] = 1'b1;
        set_prn[1][2]       = 6'd12;
        tick();
        clear_wake();
        chk("t7_woken_v",   64'(bus.iss_valid), 64'd0);
        tick();
        chk("t7_dep_ext",   64'(bus.iss_inst_id), 64'd51);
        chk("t7_occ_ext",   64'(occupancy), 64'd0);
`endif
        tick();
        chk("t7_drain", 64'(bus.iss_valid), 64'd0);

        // asynchronous reset mid-operation
        drive_enq(6'd60, 3'b001, 3'b001, {6'd0, 6'd0, 6'd4}, 3'b000, '0);
        tick();
        drive_enq(6'd61, 3'b001, 3'b000, {6'd0, 6'd0, 6'd5}, 3'b000, '0);
        bus.iss_ready = 1'b0;
        tick();
        no_enq();
        chk("t8_pre_v",   64'(bus.iss_valid), 64'd1);
        chk("t8_pre_occ", 64'(occupancy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t8_rst_v",   64'(bus.iss_valid), 64'd0);
        chk("t8_rst_occ", 64'(occupancy), 64'd0);
        chk("t8_rst_qr",  64'(bus.queue_ready), 64'd1);
        rst = 1'b0;
        bus.iss_ready = 1'b1;
        set_prn_ready[2][1] = 1'b1;
        set_prn[2][1]       = 6'd5;
        tick();
        clear_wake();
        tick();
        chk("t8_after_v", 64'(bus.iss_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
